// File: rtl/as_pack.sv
// Shared width constants for the GPIO write buffer and its users.
package as_pack;
  localparam int unsigned nr_gpios        = 16;
  localparam int unsigned gpio_addr_width = 8;
endpackage

// File: rtl/as_gpio_wrbuf.sv
// Buffers core stores that hit the GPIO window and replays them as single-cycle
// cs_o strobes separated by a fixed idle gap.
module as_gpio_wrbuf
  import as_pack::*;
#(
  parameter logic [63:0] GPIO_BASE  = 64'h0000_0000_0000_1000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dMemWr_i,
  input  logic [63:0]                dMemAddr_i,
  input  logic [63:0]                dMemData_i,
  output logic                       stall_o,
  output logic [nr_gpios-1:0]        gpio_o,
  output logic [gpio_addr_width-1:0] gpioAddr_o,
  output logic                       cs_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = gpio_addr_width + nr_gpios;
  localparam int unsigned CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic          hit, full, empty, push, pop;
  logic [PW:0]   wptr, rptr, count;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [1:0]    state;
  logic [CW-1:0] gap_cnt;
  logic          unused_data;

  assign unused_data = ^dMemData_i[63:nr_gpios];

  assign hit     = dMemAddr_i[63:gpio_addr_width] == GPIO_BASE[63:gpio_addr_width];
  assign count   = wptr - rptr;
  assign full    = count == DEPTH_C;
  assign empty   = count == '0;
  assign stall_o = dMemWr_i & hit & full;
  assign push    = dMemWr_i & hit & ~full;

  // The last gap cycle doubles as the idle cycle, so a queued entry pops there
  // and the low time between strobes is exactly GAP_CYC cycles.
  assign pop = ~empty & ((state == IDLE) | ((state == GAP) & (gap_cnt == '0)));

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr[PW-1:0]] <= {dMemAddr_i[gpio_addr_width-1:0], dMemData_i[nr_gpios-1:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      gpio_o     <= '0;
      gpioAddr_o <= '0;
      cs_o       <= 1'b0;
    end else begin
      cs_o <= 1'b0;
      if (pop) begin
        {gpioAddr_o, gpio_o} <= mem[rptr[PW-1:0]];
        cs_o  <= 1'b1;
        state <= STROBE;
      end else begin
        case (state)
          STROBE: begin
            state   <= GAP;
            gap_cnt <= CW'(GAP_CYC - 1);
          end
          GAP: begin
            if (gap_cnt == '0) state <= IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
